// File: rtl/inta_pkg.sv
// +------------------------------------------------------------------+
// | inta_pkg: shared states and constants for the INTA cycle engine.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package inta_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PULSE_LOW  = 2'd1,
    ST_PULSE_HIGH = 2'd2,
    ST_DONE       = 2'd3
  } inta_state_e;

  localparam logic [7:0] MCS80_CALL_OPCODE = 8'hCD;
  localparam logic [1:0] PULSES_8086       = 2'd2;
  localparam logic [1:0] PULSES_MCS80      = 2'd3;

  // Index of the final INTA pulse for the latched CPU mode.
  function automatic logic [1:0] last_pulse_index(input logic is_8086);
    return is_8086 ? (PULSES_8086 - 2'd1) : (PULSES_MCS80 - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inta_pulse_timer.sv
// +------------------------------------------------------------------+
// | inta_pulse_timer: loadable down-counter with terminal-count flag. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module inta_pulse_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Loading N yields N+1 clocks before the terminal count clears.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/inta_cycle_generator.sv
// +------------------------------------------------------------------+
// | inta_cycle_generator: drives INTA# pulses and captures the vector |
// | (8086) or CALL target (MCS-80) returned by the 8259A.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module inta_cycle_generator
  import inta_pkg::*;
#(
  parameter int PULSE_LOW_CYCLES  = 2,
  parameter int PULSE_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        u8086_or_mcs80_config,
  input  logic [7:0]  data_bus_in,
  input  logic        vector_accept,
  output logic        interrupt_acknowledge_n,
  output logic        vector_valid,
  output logic [7:0]  interrupt_vector,
  output logic [15:0] call_address,
  output logic        opcode_error,
  output logic        busy
);

  localparam logic [3:0] C_LOW_LOAD  = 4'(PULSE_LOW_CYCLES - 1);
  localparam logic [3:0] C_HIGH_LOAD = 4'(PULSE_HIGH_CYCLES - 1);

  inta_state_e state_q;
  logic [1:0]  pulse_idx_q;
  logic        mode_8086_q;

  logic        start_req;
  logic        last_pulse;
  logic        tmr_load;
  logic [3:0]  tmr_value;
  logic        tmr_tc;

  assign start_req  = interrupt_to_cpu & interrupt_enable;
  assign last_pulse = (pulse_idx_q == last_pulse_index(mode_8086_q));

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = C_LOW_LOAD;
    case (state_q)
      ST_IDLE:       tmr_load = start_req;
      ST_PULSE_LOW: begin
        if (tmr_tc && !last_pulse) begin
          tmr_load  = 1'b1;
          tmr_value = C_HIGH_LOAD;
        end
      end
      ST_PULSE_HIGH: tmr_load = tmr_tc;
      default:       tmr_load = 1'b0;
    endcase
  end

  inta_pulse_timer #(
    .WIDTH(4)
  ) u_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .tc_o         (tmr_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q                 <= ST_IDLE;
      pulse_idx_q             <= 2'd0;
      mode_8086_q             <= 1'b0;
      interrupt_acknowledge_n <= 1'b1;
      vector_valid            <= 1'b0;
      busy                    <= 1'b0;
      opcode_error            <= 1'b0;
      interrupt_vector        <= 8'h00;
      call_address            <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q                 <= ST_PULSE_LOW;
            pulse_idx_q             <= 2'd0;
            mode_8086_q             <= u8086_or_mcs80_config;
            interrupt_acknowledge_n <= 1'b0;
            busy                    <= 1'b1;
            opcode_error            <= 1'b0;
          end
        end
        ST_PULSE_LOW: begin
          if (tmr_tc) begin
            // The bus is only trusted on the final low clock of a pulse.
            if (mode_8086_q) begin
              if (pulse_idx_q == 2'd1) begin
                interrupt_vector <= data_bus_in;
              end
            end else begin
              case (pulse_idx_q)
                2'd0:    opcode_error       <= (data_bus_in != MCS80_CALL_OPCODE);
                2'd1:    call_address[7:0]  <= data_bus_in;
                2'd2:    call_address[15:8] <= data_bus_in;
                default: call_address       <= call_address;
              endcase
            end
            interrupt_acknowledge_n <= 1'b1;
            if (last_pulse) begin
              state_q      <= ST_DONE;
              vector_valid <= 1'b1;
            end else begin
              state_q <= ST_PULSE_HIGH;
            end
          end
        end
        ST_PULSE_HIGH: begin
          if (tmr_tc) begin
            state_q                 <= ST_PULSE_LOW;
            pulse_idx_q             <= pulse_idx_q + 2'd1;
            interrupt_acknowledge_n <= 1'b0;
          end
        end
        ST_DONE: begin
          if (vector_accept) begin
            state_q      <= ST_IDLE;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inta_cycle_generator.sv
// +------------------------------------------------------------------+
// | tb_inta_cycle_generator: scoreboard bench for the INTA generator. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_inta_cycle_generator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        interrupt_to_cpu = 1'b0;
  logic        interrupt_enable = 1'b0;
  logic        u8086_or_mcs80_config = 1'b1;
  logic [7:0]  data_bus_in = 8'h00;
  logic        vector_accept = 1'b0;
  logic        interrupt_acknowledge_n;
  logic        vector_valid;
  logic [7:0]  interrupt_vector;
  logic [15:0] call_address;
  logic        opcode_error;
  logic        busy;

  inta_cycle_generator #(
    .PULSE_LOW_CYCLES  (2),
    .PULSE_HIGH_CYCLES (2)
  ) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_to_cpu        (interrupt_to_cpu),
    .interrupt_enable        (interrupt_enable),
    .u8086_or_mcs80_config   (u8086_or_mcs80_config),
    .data_bus_in             (data_bus_in),
    .vector_accept           (vector_accept),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .vector_valid            (vector_valid),
    .interrupt_vector        (interrupt_vector),
    .call_address            (call_address),
    .opcode_error            (opcode_error),
    .busy                    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          pulses;
    logic [7:0]  vec;
    logic [15:0] call;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bus_bytes [3];
  int         bus_idx = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bus model: present the next byte whenever INTA# falls.
  initial begin
    forever begin
      @(negedge interrupt_acknowledge_n);
      data_bus_in = bus_bytes[bus_idx];
      if (bus_idx < 2) bus_idx++;
    end
  end

  // Monitor: pulse timing and result comparison against the scoreboard.
  initial begin
    logic prev_inta  = 1'b1;
    logic prev_valid = 1'b0;
    int   low_run = 0, high_run = 0, pulse_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_inta = 1'b1; prev_valid = 1'b0;
        low_run = 0; high_run = 0; pulse_cnt = 0;
      end else begin
        if (!interrupt_acknowledge_n) begin
          if (prev_inta && pulse_cnt > 0) chk("gap_len", high_run, 2);
          low_run++;
        end else if (!prev_inta) begin
          chk("low_len", low_run, 2);
          pulse_cnt++;
          low_run = 0;
          high_run = 1;
        end else begin
          high_run++;
        end
        if (vector_valid) chk("no_inta_in_done", interrupt_acknowledge_n, 1);
        if (vector_valid && !prev_valid) begin
          chk("valid_latency", prev_inta, 0);
          if (sb.size() == 0) begin
            chk("unexpected_vector", vector_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("pulse_count", pulse_cnt, e.pulses);
            chk("interrupt_vector", interrupt_vector, e.vec);
            chk("call_address", call_address, e.call);
            chk("opcode_error", opcode_error, e.err);
          end
          pulse_cnt = 0;
        end
        prev_inta  = interrupt_acknowledge_n;
        prev_valid = vector_valid;
      end
    end
  end

  task automatic load_seq(input logic [7:0] b0, b1, b2, input int pulses,
                          input logic [7:0] ev, input logic [15:0] ec, input logic ee);
    exp_t e;
    e.pulses = pulses; e.vec = ev; e.call = ec; e.err = ee;
    sb.push_back(e);
    bus_bytes[0] = b0; bus_bytes[1] = b1; bus_bytes[2] = b2;
    bus_idx = 0;
  endtask

  task automatic issue(input logic m, input logic [7:0] b0, b1, b2, input int pulses,
                       input logic [7:0] ev, input logic [15:0] ec, input logic ee);
    load_seq(b0, b1, b2, pulses, ev, ec, ee);
    @(negedge clock);
    u8086_or_mcs80_config = m;
    interrupt_to_cpu = 1'b1;
    interrupt_enable = 1'b1;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy; i++) @(negedge clock);
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_done(input bit drop);
    for (int i = 0; i < 200 && !vector_valid; i++) @(negedge clock);
    chk("done_seen", vector_valid, 1);
    if (drop) begin
      interrupt_to_cpu = 1'b0;
      interrupt_enable = 1'b0;
    end
  endtask

  task automatic accept();
    vector_accept = 1'b1;
    @(negedge clock);
    vector_accept = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lows;
    bus_bytes[0] = 8'h00; bus_bytes[1] = 8'h00; bus_bytes[2] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_inta", interrupt_acknowledge_n, 1);
    chk("rst_valid", vector_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vec", interrupt_vector, 8'h00);
    chk("rst_call", call_address, 16'h0000);
    chk("rst_err", opcode_error, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // 8086 basic: pulse-0 byte discarded.
    issue(1'b1, 8'hFF, 8'h48, 8'h00, 2, 8'h48, 16'h0000, 1'b0);
    wait_busy(); wait_done(1); accept();

    // MCS-80 good CALL.
    issue(1'b0, 8'hCD, 8'h20, 8'h3F, 3, 8'h48, 16'h3F20, 1'b0);
    wait_busy(); wait_done(1); accept();

    // MCS-80 bad opcode still completes.
    issue(1'b0, 8'hC3, 8'h11, 8'h22, 3, 8'h48, 16'h2211, 1'b1);
    wait_busy(); wait_done(1); accept();

    // INT dropped after pulse 0; opcode_error cleared at start.
    issue(1'b1, 8'h00, 8'h5A, 8'h00, 2, 8'h5A, 16'h2211, 1'b0);
    wait_busy();
    repeat (3) @(negedge clock);
    interrupt_to_cpu = 1'b0; interrupt_enable = 1'b0;
    wait_done(1); accept();

    // Mode toggled mid-sequence, both directions.
    issue(1'b1, 8'h01, 8'h77, 8'h00, 2, 8'h77, 16'h2211, 1'b0);
    wait_busy();
    repeat (2) @(negedge clock);
    u8086_or_mcs80_config = 1'b0;
    wait_done(1); accept();

    issue(1'b0, 8'hCD, 8'h34, 8'h12, 3, 8'h77, 16'h1234, 1'b0);
    wait_busy();
    repeat (2) @(negedge clock);
    u8086_or_mcs80_config = 1'b1;
    wait_done(1); accept();

    // DONE hold with INT still asserted, then one idle clock before restart.
    issue(1'b1, 8'h00, 8'h99, 8'h00, 2, 8'h99, 16'h1234, 1'b0);
    wait_busy(); wait_done(0);
    repeat (10) begin
      @(negedge clock);
      chk("hold_valid", vector_valid, 1);
      chk("hold_inta", interrupt_acknowledge_n, 1);
    end
    load_seq(8'h00, 8'h3C, 8'h00, 2, 8'h3C, 16'h1234, 1'b0);
    vector_accept = 1'b1;
    @(negedge clock);
    vector_accept = 1'b0;
    chk("exit_valid", vector_valid, 0);
    chk("idle_inta", interrupt_acknowledge_n, 1);
    chk("idle_busy", busy, 0);
    @(negedge clock);
    chk("restart_inta", interrupt_acknowledge_n, 0);
    wait_done(1); accept();

    // Reset during the 2nd low clock of pulse 1: nothing reported.
    bus_bytes[0] = 8'h00; bus_bytes[1] = 8'hEE; bus_bytes[2] = 8'h00;
    bus_idx = 0;
    @(negedge clock);
    u8086_or_mcs80_config = 1'b1;
    interrupt_to_cpu = 1'b1; interrupt_enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 50 && lows < 4; i++) begin
      @(negedge clock);
      if (!interrupt_acknowledge_n) lows++;
    end
    chk("reach_pulse1", lows, 4);
    reset_n = 1'b0;
    interrupt_to_cpu = 1'b0; interrupt_enable = 1'b0;
    #1;
    chk("arst_inta", interrupt_acknowledge_n, 1);
    chk("arst_valid", vector_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_vec", interrupt_vector, 8'h00);
    chk("arst_call", call_address, 16'h0000);
    chk("arst_err", opcode_error, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Post-reset sequence sees cleared capture registers.
    issue(1'b1, 8'h00, 8'hA5, 8'h00, 2, 8'hA5, 16'h0000, 1'b0);
    wait_busy(); wait_done(1); accept();

    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
